exec_stage: RTL and testbench

Execute stage of the processor pipeline, directly downstream of the instruction decoder. Accepts one decoded operation (opcode, destination, two operands, immediate) per handshake, computes the ALU result, branch decision or general-purpose output, and presents a single buffered result to write-back. Simple ops take one cycle. MUL runs on an iterative multi-cycle multiplier; the stage back-pressures decode while MUL is busy.

---
 rtl/exec_pkg.sv | 68 ++++++
 rtl/exec_mul_iter.sv | 55 +++++
 rtl/exec_stage.sv | 127 ++++++++++++
 tb/tb_exec_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared types, widths and decode helper for the execute stage
// Purpose : opcode and FSM state enums, width constants, and the single-cycle
//           result decoder used by exec_stage for every op except MUL.
// Contents: DATA_W, RD_W, BT_W, GP_W; op_e; state_e; res_t; exec_decode().
package exec_pkg;

  localparam int DATA_W = 32;
  localparam int RD_W   = 7;
  localparam int BT_W   = 9;
  localparam int GP_W   = 18;

  typedef enum logic [4:0] {
    OP_NOP = 5'd0,
    OP_LV  = 5'd1,
    OP_ADD = 5'd2,
    OP_SUB = 5'd3,
    OP_MUL = 5'd4,
    OP_AND = 5'd5,
    OP_CP  = 5'd6,
    OP_B   = 5'd7,
    OP_BEQ = 5'd8,
    OP_SLR = 5'd9,
    OP_GP  = 5'd10
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              wr_en;
    logic              br_taken;
    logic [BT_W-1:0]   br_target;
  } res_t;

  // MUL decodes as NOP here; the top overrides it when the multiplier exists.
  function automatic res_t exec_decode(
    input logic [4:0]        op,
    input logic [RD_W-1:0]   rd,
    input logic [DATA_W-1:0] rs,
    input logic [DATA_W-1:0] rt,
    input logic [DATA_W-1:0] imm
  );
    res_t r;
    r = '0;
    case (op)
      OP_LV, OP_CP: begin r.data = imm;          r.wr_en = 1'b1; end
      OP_ADD:       begin r.data = rs + rt;      r.wr_en = 1'b1; end
      OP_SUB:       begin r.data = rs - rt;      r.wr_en = 1'b1; end
      OP_AND:       begin r.data = rs & rt;      r.wr_en = 1'b1; end
      OP_SLR:       begin r.data = rs << rt[4:0]; r.wr_en = 1'b1; end
      OP_B: begin
        r.br_taken  = 1'b1;
        r.br_target = {{(BT_W-RD_W){1'b0}}, rd};
      end
      OP_BEQ: begin
        r.br_taken  = ({{(DATA_W-RD_W){1'b0}}, rd} == rs);
        r.br_target = rt[BT_W-1:0];
      end
      default: ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// rtl/exec_mul_iter.sv - iterative unsigned 32x32 shift-add multiplier, low 32 bits
// Purpose : one shift-add step per cycle for 32 cycles after start.
// Ports   : clock, reset (async, active-high), start (load operands),
//           a, b (operands), done (final step this cycle), product (valid with done).
// Built only when EXEC_MUL_EN is defined.
`ifdef EXEC_MUL_EN
module exec_mul_iter
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic              r_busy;
  logic [4:0]        r_cnt;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] w_step;

  assign w_step  = r_b[0] ? (r_acc + r_a) : r_acc;
  // The last step's sum is presented directly so the caller can register it
  // on the same edge that retires the multiplier.
  assign done    = r_busy && (r_cnt == 5'd31);
  assign product = w_step;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_cnt  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= '0;
      r_a    <= a;
      r_b    <= b;
      r_acc  <= '0;
    end else if (r_busy) begin
      r_acc <= w_step;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_busy <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/exec_stage.sv
// rtl/exec_stage.sv - execute stage: ALU, branch resolve, GP output, buffered result
// Purpose : accepts one decoded op per handshake and holds one result for write-back.
// Ports   : clock, reset (async, active-high);
//           in_valid/in_ready, op_code, op_rd, op_rs, op_rt, op_imm (decode side);
//           out_valid/out_ready, res_data, res_rd, res_wr_en, br_taken, br_target
//           (write-back side); gp_out (persistent general-purpose output).
// Option  : EXEC_MUL_EN builds the iterative multiplier and BUSY state; without it
//           opcode 4 is a one-cycle NOP.
module exec_stage
  import exec_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_code,
  input  logic [RD_W-1:0]   op_rd,
  input  logic [DATA_W-1:0] op_rs,
  input  logic [DATA_W-1:0] op_rt,
  input  logic [DATA_W-1:0] op_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [RD_W-1:0]   res_rd,
  output logic              res_wr_en,
  output logic              br_taken,
  output logic [BT_W-1:0]   br_target,
  output logic [GP_W-1:0]   gp_out
);

  state_e            r_state;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_res_data;
  logic [RD_W-1:0]   r_res_rd;
  logic              r_res_wr_en;
  logic              r_br_taken;
  logic [BT_W-1:0]   r_br_target;
  logic [GP_W-1:0]   r_gp;

  logic              w_accept;
  logic              w_is_mul;
  res_t              w_dec;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_dec     = exec_decode(op_code, op_rd, op_rs, op_rt, op_imm);

`ifdef EXEC_MUL_EN
  logic              w_mul_done;
  logic [DATA_W-1:0] w_mul_product;

  assign w_is_mul = (op_code == OP_MUL);

  exec_mul_iter u_mul (
    .clock   (clock),
    .reset   (reset),
    .start   (w_accept && w_is_mul),
    .a       (op_rs),
    .b       (op_rt),
    .done    (w_mul_done),
    .product (w_mul_product)
  );
`else
  assign w_is_mul = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_rd    <= '0;
      r_res_wr_en <= 1'b0;
      r_br_taken  <= 1'b0;
      r_br_target <= '0;
      r_gp        <= '0;
    end else begin
      if (w_accept && (op_code == OP_GP)) r_gp <= op_rs[GP_W-1:0];
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_accept) begin
            r_res_rd <= op_rd;
            if (w_is_mul) begin
              // Destination is captured now; data arrives when the multiplier retires.
              r_out_valid <= 1'b0;
              r_res_data  <= '0;
              r_res_wr_en <= 1'b0;
              r_br_taken  <= 1'b0;
              r_br_target <= '0;
              r_state     <= ST_BUSY;
            end else begin
              r_out_valid <= 1'b1;
              r_res_data  <= w_dec.data;
              r_res_wr_en <= w_dec.wr_en;
              r_br_taken  <= w_dec.br_taken;
              r_br_target <= w_dec.br_target;
              r_state     <= ST_DONE;
            end
          end else if ((r_state == ST_DONE) && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
`ifdef EXEC_MUL_EN
        ST_BUSY: begin
          if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_res_data  <= w_mul_product;
            r_res_wr_en <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign res_data  = r_res_data;
  assign res_rd    = r_res_rd;
  assign res_wr_en = r_res_wr_en;
  assign br_taken  = r_br_taken;
  assign br_target = r_br_target;
  assign gp_out    = r_gp;

endmodule

// File: tb/tb_exec_stage.sv
// tb/tb_exec_stage.sv - directed vector bench for exec_stage
module tb_exec_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  op_code = '0;
  logic [6:0]  op_rd = '0;
  logic [31:0] op_rs = '0;
  logic [31:0] op_rt = '0;
  logic [31:0] op_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res_data;
  logic [6:0]  res_rd;
  logic        res_wr_en;
  logic        br_taken;
  logic [8:0]  br_target;
  logic [17:0] gp_out;

  int total = 0;
  int bad = 0;

  exec_stage dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_code   (op_code),
    .op_rd     (op_rd),
    .op_rs     (op_rs),
    .op_rt     (op_rt),
    .op_imm    (op_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_data  (res_data),
    .res_rd    (res_rd),
    .res_wr_en (res_wr_en),
    .br_taken  (br_taken),
    .br_target (br_target),
    .gp_out    (gp_out)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [6:0] rd,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] imm);
    op_code = op; op_rd = rd; op_rs = rs; op_rt = rt; op_imm = imm;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [6:0]  rd;
    logic [31:0] rs, rt, imm;
    logic [31:0] data;
    logic        wr;
    logic        bt;
    logic [8:0]  tgt;
  } vec_t;

  vec_t v[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [17:0] exp_gp;
    int got;
    int rdy_seen;
    int ov_seen;

    v[0]  = '{5'd2,  7'd3,   32'd7,          32'd5,          32'd0,          32'd12,         1'b1, 1'b0, 9'h000};
    v[1]  = '{5'd3,  7'd4,   32'd0,          32'd1,          32'd0,          32'hFFFF_FFFF,  1'b1, 1'b0, 9'h000};
    v[2]  = '{5'd9,  7'd5,   32'd1,          32'h24,         32'd0,          32'd16,         1'b1, 1'b0, 9'h000};
    v[3]  = '{5'd5,  7'd6,   32'hF0F0_1234,  32'h0FF0_FF00,  32'd0,          32'h00F0_1200,  1'b1, 1'b0, 9'h000};
    v[4]  = '{5'd1,  7'd7,   32'd9,          32'd9,          32'hDEAD_BEEF,  32'hDEAD_BEEF,  1'b1, 1'b0, 9'h000};
    v[5]  = '{5'd10, 7'd1,   32'h0003_FFFF,  32'd0,          32'd0,          32'd0,          1'b0, 1'b0, 9'h000};
    v[6]  = '{5'd6,  7'h7F,  32'd0,          32'd0,          32'h1234_5678,  32'h1234_5678,  1'b1, 1'b0, 9'h000};
    v[7]  = '{5'd8,  7'd5,   32'd5,          32'h1A3,        32'd0,          32'd0,          1'b0, 1'b1, 9'h1A3};
    v[8]  = '{5'd8,  7'd5,   32'd6,          32'h1A3,        32'd0,          32'd0,          1'b0, 1'b0, 9'h1A3};
    v[9]  = '{5'd7,  7'h55,  32'd0,          32'd0,          32'd0,          32'd0,          1'b0, 1'b1, 9'h055};
    v[10] = '{5'd0,  7'd2,   32'd3,          32'd4,          32'd5,          32'd0,          1'b0, 1'b0, 9'h000};
    v[11] = '{5'd31, 7'd2,   32'd3,          32'd4,          32'd5,          32'd0,          1'b0, 1'b0, 9'h000};
    v[12] = '{5'd2,  7'd9,   32'hFFFF_FFFF,  32'd2,          32'd0,          32'd1,          1'b1, 1'b0, 9'h000};

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_rd", {25'd0, res_rd}, 32'd0);
    chk("rst_wr_en", {31'd0, res_wr_en}, 32'd0);
    chk("rst_br_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_br_target", {23'd0, br_target}, 32'd0);
    chk("rst_gp_out", {14'd0, gp_out}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-to-back table, one result per cycle
    exp_gp = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(v[i].op, v[i].rd, v[i].rs, v[i].rt, v[i].imm);
      in_valid = 1'b1;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clock);
      #1;
      if (v[i].op == 5'd10) exp_gp = v[i].rs[17:0];
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_res_data", i), res_data, v[i].data);
      chk($sformatf("v%0d_wr_en", i), {31'd0, res_wr_en}, {31'd0, v[i].wr});
      chk($sformatf("v%0d_br_taken", i), {31'd0, br_taken}, {31'd0, v[i].bt});
      if (v[i].bt || v[i].op == 5'd8)
        chk($sformatf("v%0d_br_target", i), {23'd0, br_target}, {23'd0, v[i].tgt});
      if (v[i].wr)
        chk($sformatf("v%0d_res_rd", i), {25'd0, res_rd}, {25'd0, v[i].rd});
      chk($sformatf("v%0d_gp_out", i), {14'd0, gp_out}, {14'd0, exp_gp});
    end
    in_valid = 1'b0;
    @(posedge clock);
    #1;
    chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_in_ready", {31'd0, in_ready}, 32'd1);

    // Back-pressure: ADD held in DONE while the next op waits
    drive(5'd2, 7'd3, 32'd7, 32'd5, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    drive(5'd3, 7'd9, 32'd10, 32'd3, 32'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_res_data", k), res_data, 32'd12);
      chk($sformatf("bp%0d_res_rd", k), {25'd0, res_rd}, 32'd3);
      @(posedge clock);
      #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("bp_queued_data", res_data, 32'd7);
    chk("bp_queued_rd", {25'd0, res_rd}, 32'd9);
    chk("bp_queued_valid", {31'd0, out_valid}, 32'd1);
    chk("gp_persist", {14'd0, gp_out}, 32'h3FFFF);
    @(posedge clock);
    #1;

`ifdef EXEC_MUL_EN
    // MUL latency: 32 cycles of in_ready low
    drive(5'd4, 7'd8, 32'd1000, 32'd3000, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    got = 0;
    rdy_seen = 0;
    if (in_ready) rdy_seen++;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        got = k;
        break;
      end
      if (in_ready) rdy_seen++;
    end
    chk("mul_latency", got, 32'd32);
    chk("mul_in_ready_low", rdy_seen, 32'd0);
    chk("mul_res_data", res_data, 32'd3000000);
    chk("mul_res_rd", {25'd0, res_rd}, 32'd8);
    chk("mul_wr_en", {31'd0, res_wr_en}, 32'd1);

    // Reset at BUSY cycle 10 discards the product
    drive(5'd4, 7'd8, 32'd1000, 32'd3000, 32'd0);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mulrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mulrst_res_data", res_data, 32'd0);
    chk("mulrst_gp_out", {14'd0, gp_out}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("mulrst_in_ready", {31'd0, in_ready}, 32'd1);
    ov_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) ov_seen++;
    end
    chk("mulrst_no_result", ov_seen, 32'd0);
`else
    // Opcode 4 without the multiplier: one-cycle NOP
    drive(5'd4, 7'd8, 32'd1000, 32'd3000, 32'd0);
    in_valid = 1'b1;
    #1;
    chk("nomul_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("nomul_out_valid", {31'd0, out_valid}, 32'd1);
    chk("nomul_wr_en", {31'd0, res_wr_en}, 32'd0);
    chk("nomul_res_data", res_data, 32'd0);
    chk("nomul_br_taken", {31'd0, br_taken}, 32'd0);
    @(posedge clock);
    #1;
`endif

    // Async reset while a result is held clears everything
    out_ready = 1'b0;
    drive(5'd1, 7'd11, 32'h0001_2345, 32'd0, 32'hCAFE_F00D);
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    drive(5'd10, 7'd0, 32'h0001_2345, 32'd0, 32'd0);
    chk("hold_res_data", res_data, 32'hCAFE_F00D);
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    chk("gp_update", {14'd0, gp_out}, 32'h12345);
    #2;
    reset = 1'b1;
    #1;
    chk("final_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("final_rst_gp_out", {14'd0, gp_out}, 32'd0);
    chk("final_rst_res_rd", {25'd0, res_rd}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
